// File: rtl/mem_busio_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_busio_if
//  Description : External memory bus bundle between the memory-stage bus
//                responder (master) and the memory/bus fabric (slave).
//                Word-oriented valid/ready request channel plus a response
//                strobe shared by reads and writes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_busio_if;
    logic        ext_valid;
    logic        ext_ready;
    logic        ext_write;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_strobe;
    logic        ext_resp;
    logic [31:0] ext_read_data;

    modport master (
        output ext_valid,
        output ext_write,
        output ext_address,
        output ext_write_data,
        output ext_strobe,
        input  ext_ready,
        input  ext_resp,
        input  ext_read_data
    );

    modport slave (
        input  ext_valid,
        input  ext_write,
        input  ext_address,
        input  ext_write_data,
        input  ext_strobe,
        output ext_ready,
        output ext_resp,
        output ext_read_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_busio.sv
`default_nettype none
// ============================================================================
//  Module      : mem_busio
//  Description : Bus-side responder for the memory pipeline stage. Turns the
//                stage's load/store request into one word transaction on the
//                external bus, returns aligned and extended load data, and
//                holds the pipeline via mem_busy until the access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_busio (
    input  wire         clk,
    input  wire         reset,
    input  wire  [31:0] mem_address,
    input  wire  [31:0] mem_store_data,
    input  wire  [1:0]  mem_size,
    input  wire         mem_signed,
    input  wire         mem_load,
    input  wire         mem_store,
    input  wire         accept,
    output logic [31:0] mem_load_data,
    output logic        mem_busy,
    mem_busio_if.master bus
);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_REQ  = 2'd1,
        c_RESP = 2'd2,
        c_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Request fields captured when leaving IDLE; held stable for the bus
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strobe;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_off;
    logic [31:0] r_load_data;

    logic        w_req;
    logic        w_valid;
    logic [31:0] w_wdata;
    logic [3:0]  w_strobe;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;

    // A size code of 11 is not a transfer; store wins when both flags are set
    assign w_req = (mem_load | mem_store) & (mem_size != 2'b11);

    // Replicate store data across byte lanes and pick the lanes to write
    always_comb begin
        w_wdata  = mem_store_data;
        w_strobe = 4'b1111;
        case (mem_size)
            2'b00: begin
                w_wdata  = {4{mem_store_data[7:0]}};
                w_strobe = 4'b0001 << mem_address[1:0];
            end
            2'b01: begin
                w_wdata  = {2{mem_store_data[15:0]}};
                w_strobe = 4'b0011 << {mem_address[1], 1'b0};
            end
            default: begin
                w_wdata  = mem_store_data;
                w_strobe = 4'b1111;
            end
        endcase
        if (!mem_store) begin
            w_strobe = 4'b0000;
        end
    end

    // Align the returned word to the requested byte and extend to 32 bits
    always_comb begin
        w_shifted = bus.ext_read_data >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_load_ext = {{24{r_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load_ext = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    // Next-state and handshake outputs; DONE waits for the stage to advance
    // so a request still presented is not issued twice
    always_comb begin
        w_next   = r_state;
        mem_busy = 1'b0;
        w_valid  = 1'b0;
        case (r_state)
            c_IDLE: begin
                mem_busy = w_req;
                if (w_req) begin
                    w_next = c_REQ;
                end
            end
            c_REQ: begin
                mem_busy = 1'b1;
                w_valid  = 1'b1;
                if (bus.ext_ready) begin
                    w_next = c_RESP;
                end
            end
            c_RESP: begin
                mem_busy = 1'b1;
                if (bus.ext_resp) begin
                    w_next = c_DONE;
                end
            end
            c_DONE: begin
                if (accept) begin
                    w_next = c_IDLE;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // State register, request capture and load-result latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_strobe    <= 4'd0;
            r_write     <= 1'b0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_off       <= 2'd0;
            r_load_data <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == c_IDLE && w_req) begin
                r_addr   <= {mem_address[31:2], 2'b00};
                r_wdata  <= w_wdata;
                r_strobe <= w_strobe;
                r_write  <= mem_store;
                r_size   <= mem_size;
                r_signed <= mem_signed;
                r_off    <= mem_address[1:0];
            end
            if (r_state == c_RESP && bus.ext_resp && !r_write) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    assign bus.ext_valid      = w_valid;
    assign bus.ext_write      = r_write;
    assign bus.ext_address    = r_addr;
    assign bus.ext_write_data = r_wdata;
    assign bus.ext_strobe     = r_strobe;
    assign mem_load_data      = r_load_data;

endmodule
`default_nettype wire
